// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared states, default sizes and lane slicing for the MMU operand path
package mmu_pkg;

    // Defaults shared with MMU_gen instantiations
    localparam int MMU_NUM_INP   = 4;
    localparam int MMU_DATA_SIZE = 15;
    localparam int MMU_NUM_CALC  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_PAD,
        ST_DRAIN,
        ST_DONE
    } feed_state_t;

    // Lowest bit of lane `lane` in a row packed as lanes of `width` bits
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mmu_skew_line.sv
// rtl/mmu_skew_line.sv - fixed-depth delay line carrying one lane's data and valid
module mmu_skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            valid_q;

    // Shift data and valid together one stage per cycle; reset empties the line
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/mmu_skew_feeder.sv
// rtl/mmu_skew_feeder.sv - row intake, zero padding and diagonal skew toward the systolic array edge
module mmu_skew_feeder
    import mmu_pkg::*;
#(
    parameter  int NUM_INP   = MMU_NUM_INP,
    parameter  int DATA_SIZE = MMU_DATA_SIZE,
    parameter  int NUM_CALC  = MMU_NUM_CALC,
    localparam int CALC_W    = (NUM_CALC > 1) ? $clog2(NUM_CALC) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_INP*DATA_SIZE-1:0]  in_row,
    input  logic                          in_last,
    output logic [NUM_INP*DATA_SIZE-1:0]  edge_data,
    output logic [NUM_INP-1:0]            edge_valid,
    output logic                          load,
    output logic                          busy,
    output logic [CALC_W-1:0]             calc_count,
    output logic                          batch_done
);

    localparam int CNT_W = $clog2(NUM_INP + 1);
    localparam logic [CNT_W-1:0]  ROW_LAST   = CNT_W'(NUM_INP - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'((NUM_INP > 1) ? NUM_INP - 2 : 0);
    localparam logic [CALC_W-1:0] CALC_LAST  = CALC_W'(NUM_CALC - 1);

    feed_state_t                  state_q, state_d;
    logic [CNT_W-1:0]             row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]             drain_cnt_q, drain_cnt_d;
    logic [CALC_W-1:0]            calc_count_q, calc_count_d;
    logic [NUM_INP*DATA_SIZE-1:0] inj_data;
    logic                         inj_valid;
    logic                         xfer;

    // State, row/drain counters and completed-matrix counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            calc_count_q <= '0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            calc_count_q <= calc_count_d;
        end
    end

    // Next state, what enters the skew lines this cycle, and handshake/pulse outputs
    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        calc_count_d = calc_count_q;
        inj_data     = '0;
        inj_valid    = 1'b0;
        load         = 1'b0;
        batch_done   = 1'b0;
        in_ready     = !rst && ((state_q == ST_IDLE) || (state_q == ST_FEED));
        xfer         = in_valid && in_ready;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    inj_data    = in_row;
                    inj_valid   = 1'b1;
                    row_cnt_d   = CNT_W'(1);
                    drain_cnt_d = '0;
                    // A single-row matrix has no skew to drain
                    if (NUM_INP == 1) begin
                        state_d = ST_DONE;
                    end else if (in_last) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FEED;
                    end
                end
            end
            ST_FEED: begin
                if (xfer) begin
                    inj_data  = in_row;
                    inj_valid = 1'b1;
                    row_cnt_d = row_cnt_q + 1'b1;
                    // The final row wins over in_last: nothing left to pad
                    if (row_cnt_q == ROW_LAST) begin
                        state_d = ST_DRAIN;
                    end else if (in_last) begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                inj_valid = 1'b1;
                row_cnt_d = row_cnt_q + 1'b1;
                if (row_cnt_q == ROW_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                load      = 1'b1;
                row_cnt_d = '0;
                state_d   = ST_IDLE;
                if (calc_count_q == CALC_LAST) begin
                    calc_count_d = '0;
                    batch_done   = 1'b1;
                end else begin
                    calc_count_d = calc_count_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign calc_count = calc_count_q;

    // Lane k is delayed k+1 cycles so the rows leave as a diagonal wavefront
    for (genvar k = 0; k < NUM_INP; k++) begin : g_lane
        mmu_skew_line #(
            .DEPTH (k + 1),
            .WIDTH (DATA_SIZE)
        ) u_line (
            .clk     (clk),
            .rst     (rst),
            .data_i  (inj_data[lane_lsb(k, DATA_SIZE) +: DATA_SIZE]),
            .valid_i (inj_valid),
            .data_o  (edge_data[lane_lsb(k, DATA_SIZE) +: DATA_SIZE]),
            .valid_o (edge_valid[k])
        );
    end

endmodule

// File: tb/tb_mmu_skew_feeder.sv
// tb/tb_mmu_skew_feeder.sv - directed scoreboard bench for the skew feeder (4-lane and 1-lane builds)
module tb_mmu_skew_feeder;

    localparam int N  = 4;
    localparam int DS = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*DS-1:0] in_row;
    logic            in_last;
    logic [N*DS-1:0] edge_data;
    logic [N-1:0]    edge_valid;
    logic            load;
    logic            busy;
    logic [1:0]      calc_count;
    logic            batch_done;

    logic            rst1;
    logic            v1;
    logic            rdy1;
    logic [DS-1:0]   row1;
    logic            last1;
    logic [DS-1:0]   ed1;
    logic [0:0]      ev1;
    logic            load1;
    logic            busy1;
    logic [0:0]      cc1;
    logic            bd1;

    always #5 clk = ~clk;

    mmu_skew_feeder #(.NUM_INP(N), .DATA_SIZE(DS), .NUM_CALC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .in_last    (in_last),
        .edge_data  (edge_data),
        .edge_valid (edge_valid),
        .load       (load),
        .busy       (busy),
        .calc_count (calc_count),
        .batch_done (batch_done)
    );

    mmu_skew_feeder #(.NUM_INP(1), .DATA_SIZE(DS), .NUM_CALC(2)) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .in_valid   (v1),
        .in_ready   (rdy1),
        .in_row     (row1),
        .in_last    (last1),
        .edge_data  (ed1),
        .edge_valid (ev1),
        .load       (load1),
        .busy       (busy1),
        .calc_count (cc1),
        .batch_done (bd1)
    );

    typedef struct {
        int            due;
        int            lane;
        logic [DS-1:0] data;
    } lane_exp_t;

    lane_exp_t exp_q[$];
    int        load_q[$];
    int        cyc      = 0;
    int        n_cmp    = 0;
    int        n_err    = 0;
    int        exp_calc = 0;
    int        e1_calc  = 0;
    logic          e1_load;
    logic          e1_valid;
    logic [DS-1:0] e1_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Check one cycle at the falling edge, then advance past the next rising edge
    task automatic tick(input logic rdy, input logic bsy);
        logic          found;
        logic [DS-1:0] d;
        logic [DS-1:0] got;
        logic          ld;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        chk("busy", {31'd0, busy}, {31'd0, bsy});
        for (int k = 0; k < N; k++) begin
            found = 1'b0;
            d     = '0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].due == cyc && exp_q[i].lane == k) begin
                    found = 1'b1;
                    d     = exp_q[i].data;
                    exp_q.delete(i);
                    break;
                end
            end
            got = edge_data[k*DS +: DS];
            chk($sformatf("lane%0d_valid", k), {31'd0, edge_valid[k]}, {31'd0, found});
            chk($sformatf("lane%0d_data", k), {17'd0, got}, {17'd0, d});
        end
        ld = (load_q.size() > 0) && (load_q[0] == cyc);
        chk("load", {31'd0, load}, {31'd0, ld});
        chk("batch_done", {31'd0, batch_done}, {31'd0, ld && (exp_calc == 3)});
        chk("calc_count", {30'd0, calc_count}, exp_calc);
        if (ld) begin
            void'(load_q.pop_front());
            exp_calc = (exp_calc + 1) % 4;
        end
        chk("n1_in_ready", {31'd0, rdy1}, {31'd0, !rst1 && !e1_load});
        chk("n1_busy", {31'd0, busy1}, {31'd0, e1_load});
        chk("n1_valid", {31'd0, ev1}, {31'd0, e1_valid});
        chk("n1_data", {17'd0, ed1}, {17'd0, e1_data});
        chk("n1_load", {31'd0, load1}, {31'd0, e1_load});
        chk("n1_batch_done", {31'd0, bd1}, {31'd0, e1_load && (e1_calc == 1)});
        chk("n1_calc_count", {31'd0, cc1}, e1_calc);
        if (e1_load) e1_calc = (e1_calc + 1) % 2;
        @(posedge clk);
        #1;
        cyc++;
        e1_load  = 1'b0;
        e1_valid = 1'b0;
        e1_data  = '0;
    endtask

    // Offer a row whose lane k holds base+k; schedule its lanes when acceptance is expected
    task automatic send(input int base, input logic last, input logic rdy, input logic bsy);
        in_valid = 1'b1;
        in_last  = last;
        for (int k = 0; k < N; k++) begin
            in_row[k*DS +: DS] = DS'(base + k);
            if (rdy) exp_q.push_back('{due: cyc + 1 + k, lane: k, data: DS'(base + k)});
        end
        tick(rdy, bsy);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_row   = '0;
    endtask

    // Cycle in which a zero pad row is expected while a stray row is offered and refused
    task automatic pad_cycle();
        in_valid = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_row[k*DS +: DS] = DS'(900 + k);
            exp_q.push_back('{due: cyc + 1 + k, lane: k, data: '0});
        end
        tick(1'b0, 1'b1);
        in_valid = 1'b0;
        in_row   = '0;
    endtask

    task automatic full_matrix(input int base);
        load_q.push_back(cyc + 2 * N - 1);
        send(base, 1'b0, 1'b1, 1'b0);
        for (int r = 1; r < N; r++) send(base + 10 * r, 1'b0, 1'b1, 1'b1);
        repeat (N) tick(1'b0, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        rst1     = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_row   = '0;
        v1       = 1'b0;
        row1     = '0;
        last1    = 1'b0;
        e1_load  = 1'b0;
        e1_valid = 1'b0;
        e1_data  = '0;

        // Reset: ready low, all outputs zero
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst  = 1'b0;
        rst1 = 1'b0;

        // Back-to-back full matrix, lane k of row r = 10r+k
        full_matrix(0);
        tick(1'b1, 1'b0);

        // Reset during DRAIN discards the matrix and clears the count
        load_q.push_back(cyc + 2 * N - 1);
        send(500, 1'b0, 1'b1, 1'b0);
        for (int r = 1; r < N; r++) send(500 + 10 * r, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1);
        rst = 1'b1;
        tick(1'b0, 1'b1);
        rst = 1'b0;
        exp_q.delete();
        load_q.delete();
        exp_calc = 0;
        tick(1'b1, 1'b0);

        // Batch of four: full, in_last on row 1, two-cycle bubble, full
        full_matrix(100);

        load_q.push_back(cyc + 2 * N - 1);
        send(200, 1'b0, 1'b1, 1'b0);
        send(210, 1'b1, 1'b1, 1'b1);
        pad_cycle();
        pad_cycle();
        repeat (N) tick(1'b0, 1'b1);

        load_q.push_back(cyc + 2 * N + 1);
        send(300, 1'b0, 1'b1, 1'b0);
        send(310, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        send(320, 1'b0, 1'b1, 1'b1);
        send(330, 1'b0, 1'b1, 1'b1);
        repeat (N) tick(1'b0, 1'b1);

        full_matrix(400);
        tick(1'b1, 1'b0);

        // Single-lane build: load coincides with the only output, no drain
        v1   = 1'b1;
        row1 = DS'(16'h1234);
        tick(1'b1, 1'b0);
        v1       = 1'b0;
        row1     = '0;
        e1_load  = 1'b1;
        e1_valid = 1'b1;
        e1_data  = DS'(16'h1234);
        tick(1'b1, 1'b0);
        v1    = 1'b1;
        last1 = 1'b1;
        row1  = DS'(16'h0555);
        tick(1'b1, 1'b0);
        v1       = 1'b0;
        last1    = 1'b0;
        row1     = '0;
        e1_load  = 1'b1;
        e1_valid = 1'b1;
        e1_data  = DS'(16'h0555);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
